v3_shift_queue_array: RTL and testbench

Parametrised shift-based storage array for the operation-centric queues: `p_depth` entries of `p_bitwidth` bits, head at entry 0, contents kept contiguous in entries 0..count-1. It generalises the single multi-input register cell to a full array. It adds tail push, head pop, insert-at-index and remove-at-index, with occupancy tracking and a valid/ready op handshake. It sits between the queue controller and the consumers that read the head or peek arbitrary entries.

---
 rtl/v3_shift_queue_array.sv | 124 ++++++++++++
 tb/tb_v3_shift_queue_array.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/v3_shift_queue_array.sv
// rtl/v3_shift_queue_array.sv - shift-based queue storage array with push/pop/insert/remove
// Optional op 5 (POPPUSH) is built only when V3_SHIFT_QUEUE_POPPUSH_EN is defined.
module v3_shift_queue_array #(
  parameter int p_bitwidth = 32,
  parameter int p_depth    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_val,
  output logic                         op_rdy,
  input  logic [2:0]                   op,
  input  logic [$clog2(p_depth)-1:0]   op_idx,
  input  logic [p_bitwidth-1:0]        op_data,
  input  logic [$clog2(p_depth)-1:0]   rd_idx,
  output logic [p_bitwidth-1:0]        rd_data,
  output logic [p_bitwidth-1:0]        head_data,
  output logic [$clog2(p_depth+1)-1:0] count,
  output logic                         full,
  output logic                         empty
);
  localparam int IW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);

  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_INSERT  = 3'd3;
  localparam logic [2:0] OP_REMOVE  = 3'd4;
`ifdef V3_SHIFT_QUEUE_POPPUSH_EN
  localparam logic [2:0] OP_POPPUSH = 3'd5;
`endif

  logic [CW-1:0]                        cnt;
  logic [CW-1:0]                        idx_w;
  logic                                 fire;
  logic [p_depth-1:0][p_bitwidth-1:0]   ent;

  assign idx_w     = CW'(op_idx);
  assign fire      = op_val && op_rdy;
  assign count     = cnt;
  assign full      = (cnt == CW'(p_depth));
  assign empty     = (cnt == '0);
  assign head_data = ent[0];

  always_comb begin
    op_rdy = 1'b0;
    case (op)
      OP_IDLE:    op_rdy = 1'b1;
      OP_PUSH:    op_rdy = !full;
      OP_POP:     op_rdy = !empty;
      OP_INSERT:  op_rdy = !full && (idx_w <= cnt);
      OP_REMOVE:  op_rdy = !empty && (idx_w < cnt);
`ifdef V3_SHIFT_QUEUE_POPPUSH_EN
      OP_POPPUSH: op_rdy = !empty;
`endif
      default:    op_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (fire) begin
      case (op)
        OP_PUSH, OP_INSERT: cnt <= cnt + CW'(1);
        OP_POP, OP_REMOVE:  cnt <= cnt - CW'(1);
        default:            cnt <= cnt;
      endcase
    end
  end

`ifdef V3_SHIFT_QUEUE_POPPUSH_EN
  logic [CW-1:0] cnt_m1;
  assign cnt_m1 = cnt - CW'(1);
`endif

  // Each cell picks its source by priority: write > forward shift > reverse shift > hold.
  for (genvar g = 0; g < p_depth; g++) begin : g_cell
    localparam logic [CW-1:0] POS = CW'(g);
    logic [p_bitwidth-1:0] q;
    logic [p_bitwidth-1:0] fwd_val;
    logic [p_bitwidth-1:0] rev_val;
    logic                  wr;
    logic                  fwd;
    logic                  rev;

    if (g < p_depth - 1) begin : g_fwd
      assign fwd_val = ent[g+1];
    end else begin : g_fwd_last
      assign fwd_val = '0;
    end
    if (g > 0) begin : g_rev
      assign rev_val = ent[g-1];
    end else begin : g_rev_first
      assign rev_val = '0;
    end

    always_comb begin
      wr  = fire && ((op == OP_PUSH && POS == cnt) || (op == OP_INSERT && POS == idx_w));
      fwd = fire && (op == OP_POP || (op == OP_REMOVE && POS >= idx_w));
      rev = fire && op == OP_INSERT && POS > idx_w;
`ifdef V3_SHIFT_QUEUE_POPPUSH_EN
      wr  = wr  || (fire && op == OP_POPPUSH && POS == cnt_m1);
      fwd = fwd || (fire && op == OP_POPPUSH);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)     q <= '0;
      else if (wr)  q <= op_data;
      else if (fwd) q <= fwd_val;
      else if (rev) q <= rev_val;
    end

    assign ent[g] = q;
  end

  // Non-power-of-2 depths leave rd_idx codes past the last entry; those read as 0.
  if ((1 << IW) == p_depth) begin : g_rd_pow2
    assign rd_data = ent[rd_idx];
  end else begin : g_rd_npow2
    assign rd_data = ({1'b0, rd_idx} < (IW + 1)'(p_depth)) ? ent[rd_idx] : '0;
  end
endmodule

// File: tb/tb_v3_shift_queue_array.sv
// tb/tb_v3_shift_queue_array.sv - directed plus random checks of v3_shift_queue_array against a queue model
module tb_v3_shift_queue_array;
  localparam int D = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_val = 1'b0;
  logic          op_rdy;
  logic [2:0]    op = 3'd0;
  logic [1:0]    op_idx = 2'd0;
  logic [W-1:0]  op_data = '0;
  logic [1:0]    rd_idx = 2'd0;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  head_data;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] mq[$];

  v3_shift_queue_array #(.p_bitwidth(W), .p_depth(D)) dut (
    .clk(clk), .rst(rst), .op_val(op_val), .op_rdy(op_rdy), .op(op),
    .op_idx(op_idx), .op_data(op_data), .rd_idx(rd_idx), .rd_data(rd_data),
    .head_data(head_data), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy(input logic [2:0] o, input int i);
    int n;
    n = mq.size();
    case (o)
      3'd0: return 1'b1;
      3'd1: return n < D;
      3'd2: return n > 0;
      3'd3: return (n < D) && (i <= n);
      3'd4: return (n > 0) && (i < n);
`ifdef V3_SHIFT_QUEUE_POPPUSH_EN
      3'd5: return n > 0;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic void m_apply(input logic [2:0] o, input int i, input logic [W-1:0] d);
    case (o)
      3'd1: mq.push_back(d);
      3'd2: void'(mq.pop_front());
      3'd3: mq.insert(i, d);
      3'd4: mq.delete(i);
      3'd5: begin void'(mq.pop_front()); mq.push_back(d); end
      default: ;
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, W'(count), W'(mq.size()));
    chk({tag, ".empty"}, W'(empty), W'(mq.size() == 0));
    chk({tag, ".full"},  W'(full),  W'(mq.size() == D));
    chk({tag, ".head"},  head_data, (mq.size() > 0) ? mq[0] : '0);
    for (int r = 0; r < D; r++) begin
      rd_idx = 2'(r);
      #1;
      chk($sformatf("%s.rd%0d", tag, r), rd_data, (r < mq.size()) ? mq[r] : '0);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] o, input int i, input logic [W-1:0] d, input bit v);
    bit er;
    op = o; op_idx = 2'(i); op_data = d; op_val = v;
    #1;
    er = m_rdy(o, i);
    chk({tag, ".rdy"}, W'(op_rdy), W'(er));
    @(posedge clk);
    if (v && er) m_apply(o, i, d);
    #1;
    op_val = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    mq.delete();
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    step("pushA", 3'd1, 0, 32'hA, 1'b1);
    step("pushB", 3'd1, 0, 32'hB, 1'b1);
    step("pushC", 3'd1, 0, 32'hC, 1'b1);
    chk("abc.rd2", rd_data, (rd_idx == 2'd3) ? 32'h0 : rd_data);
    step("pushD", 3'd1, 0, 32'hD, 1'b1);
    for (int k = 0; k < 3; k++) step("full_push", 3'd1, 0, 32'hEE, 1'b1);
    step("full_ins", 3'd3, 0, 32'hEE, 1'b1);

    do_reset();
    step("p1", 3'd1, 0, 32'd1, 1'b1);
    step("p2", 3'd1, 0, 32'd2, 1'b1);
    step("p3", 3'd1, 0, 32'd3, 1'b1);
    step("ins9", 3'd3, 1, 32'd9, 1'b1);
    rd_idx = 2'd1; #1;
    chk("ins9.lit", rd_data, 32'd9);
    step("rem2", 3'd4, 2, 32'd0, 1'b1);
    rd_idx = 2'd2; #1;
    chk("rem2.lit", rd_data, 32'd3);

    do_reset();
    step("e_pop", 3'd2, 0, 32'd0, 1'b1);
    step("e_ins1", 3'd3, 1, 32'd5, 1'b1);
    step("e_ins0", 3'd3, 0, 32'd5, 1'b1);
    chk("e_ins0.lit", head_data, 32'd5);

    do_reset();
    for (int k = 1; k <= 4; k++) step("fill", 3'd1, 0, W'(k), 1'b1);
    step("poppush", 3'd5, 0, 32'd7, 1'b1);
    step("ill6", 3'd6, 0, 32'd1, 1'b1);
    step("ill7", 3'd7, 0, 32'd1, 1'b1);

    do_reset();
    for (int k = 1; k <= 3; k++) step("mfill", 3'd1, 0, W'(k), 1'b1);
    op = 3'd1; op_data = 32'h55; op_val = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    check_state("midrst");
    @(posedge clk);
    #1;
    check_state("rst_low_edge");
    op_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 3'd1, 0, 32'h66, 1'b1);

    for (int k = 0; k < 300; k++) begin
      step("rand", 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
